// File: rtl/register_file_sb_pkg.sv
// Shared defaults and helpers for the scoreboarded register file.
package register_file_sb_pkg;

   localparam int XLEN_DEF  = 32;
   localparam int DEPTH_DEF = 32;
   localparam int ZERO_REG  = 0;

   // Address width for a given register count (at least one bit).
   function automatic int addr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/register_file_sb_scoreboard.sv
// Pending-load scoreboard: per-register busy bits, outstanding-load counter,
// overflow flag and the source-operand stall decision.
module regfile_scoreboard
   import register_file_sb_pkg::*;
#(
   parameter int DEPTH    = DEPTH_DEF,
   parameter int NUM_RD   = 2,
   parameter int BYPASS   = 1,
   parameter int MAX_PEND = 4,
   parameter int ADDR_W   = addr_w(DEPTH)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   input  logic [NUM_RD-1:0]        rd_used,
   input  logic                     wb_en,
   input  logic [ADDR_W-1:0]        wb_addr,
   input  logic                     ld_issue,
   input  logic [ADDR_W-1:0]        ld_rd,
   output logic                     stall,
   output logic                     pend_full,
   output logic                     ovf
);

   localparam int CNT_W = $clog2(MAX_PEND + 1);
   localparam logic [ADDR_W-1:0] ZR = ADDR_W'(ZERO_REG);
   localparam logic [CNT_W-1:0]  MAXC = CNT_W'(MAX_PEND);

   logic [DEPTH-1:0] busy, busy_nx;
   logic [CNT_W-1:0] pend_cnt;
   logic             ld_acc;

   assign pend_full = (pend_cnt == MAXC);
   // A load arriving with the counter full is refused entirely.
   assign ld_acc    = ld_issue && !pend_full;

   // Next busy vector: clear on load return, then set on issue so set wins.
   always_comb begin
      busy_nx = busy;
      if (wb_en) busy_nx[wb_addr] = 1'b0;
      if (ld_acc && ld_rd != ZR) busy_nx[ld_rd] = 1'b1;
      busy_nx[ZERO_REG] = 1'b0;
   end

   // Busy vector, outstanding-load counter (saturating at 0) and sticky overflow.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy     <= '0;
         pend_cnt <= '0;
         ovf      <= 1'b0;
      end else begin
         busy <= busy_nx;
         case ({ld_acc, wb_en})
            2'b10:   pend_cnt <= pend_cnt + 1'b1;
            2'b01:   if (pend_cnt != '0) pend_cnt <= pend_cnt - 1'b1;
            default: pend_cnt <= pend_cnt;
         endcase
         if (ld_issue && pend_full) ovf <= 1'b1;
      end
   end

   // Stall when any used source is busy and not being returned this cycle.
   always_comb begin
      stall = 1'b0;
      for (int i = 0; i < NUM_RD; i++) begin
         if (rd_used[i] && busy[rd_addr[i*ADDR_W +: ADDR_W]] &&
             !((BYPASS != 0) && wb_en && (wb_addr == rd_addr[i*ADDR_W +: ADDR_W])))
            stall = 1'b1;
      end
   end

endmodule

// File: rtl/register_file_sb.sv
// Register file with two write ports, optional write-to-read bypass,
// pending-load scoreboard and a registered store-data channel.
module register_file_sb
   import register_file_sb_pkg::*;
#(
   parameter int XLEN     = XLEN_DEF,
   parameter int DEPTH    = DEPTH_DEF,
   parameter int NUM_RD   = 2,
   parameter int BYPASS   = 1,
   parameter int MAX_PEND = 4,
   parameter int ADDR_W   = addr_w(DEPTH)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   input  logic [NUM_RD-1:0]        rd_used,
   output logic [NUM_RD*XLEN-1:0]   rd_data,
   input  logic                     wa_en,
   input  logic [ADDR_W-1:0]        wa_addr,
   input  logic [XLEN-1:0]          wa_data,
   input  logic                     wb_en,
   input  logic [ADDR_W-1:0]        wb_addr,
   input  logic [XLEN-1:0]          wb_data,
   input  logic                     ld_issue,
   input  logic [ADDR_W-1:0]        ld_rd,
   input  logic                     st_req,
   input  logic [ADDR_W-1:0]        st_rs,
   output logic [XLEN-1:0]          st_data,
   output logic                     st_valid,
   output logic                     stall,
   output logic                     pend_full,
   output logic                     ovf
);

   // Read ports plus one extra internal port for the store source.
   localparam int NP = NUM_RD + 1;
   localparam logic [ADDR_W-1:0] ZR = ADDR_W'(ZERO_REG);

   logic [DEPTH-1:0][XLEN-1:0] regs;
   logic [NP-1:0][ADDR_W-1:0]  raddr;
   logic [NP-1:0][XLEN-1:0]    rval;

   assign raddr   = {st_rs, rd_addr};
   assign rd_data = rval[NUM_RD-1:0];

   // Register array; port A is written last so it wins an address collision.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         regs <= '0;
      end else begin
         if (wb_en && wb_addr != ZR) regs[wb_addr] <= wb_data;
         if (wa_en && wa_addr != ZR) regs[wa_addr] <= wa_data;
      end
   end

   // Combinational reads with optional forwarding (A over B); x0 always zero.
   always_comb begin
      rval = '0;
      for (int i = 0; i < NP; i++) begin
         rval[i] = regs[raddr[i]];
         if (BYPASS != 0) begin
            if (wb_en && wb_addr == raddr[i]) rval[i] = wb_data;
            if (wa_en && wa_addr == raddr[i]) rval[i] = wa_data;
         end
         if (raddr[i] == ZR) rval[i] = '0;
      end
   end

   // Store stage: capture the (bypassed) source and pulse valid for one cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st_data  <= '0;
         st_valid <= 1'b0;
      end else begin
         st_valid <= st_req;
         if (st_req) st_data <= rval[NUM_RD];
      end
   end

   regfile_scoreboard #(
      .DEPTH    (DEPTH),
      .NUM_RD   (NUM_RD),
      .BYPASS   (BYPASS),
      .MAX_PEND (MAX_PEND),
      .ADDR_W   (ADDR_W)
   ) u_sb (
      .clk       (clk),
      .reset     (reset),
      .rd_addr   (rd_addr),
      .rd_used   (rd_used),
      .wb_en     (wb_en),
      .wb_addr   (wb_addr),
      .ld_issue  (ld_issue),
      .ld_rd     (ld_rd),
      .stall     (stall),
      .pend_full (pend_full),
      .ovf       (ovf)
   );

endmodule

// File: tb/tb_register_file_sb.sv
// Directed bench: one bypassing and one non-bypassing instance share stimulus.
module tb_register_file_sb;

   logic        clk = 1'b0;
   logic        reset;
   logic [9:0]  rd_addr;
   logic [1:0]  rd_used;
   logic        wa_en, wb_en, ld_issue, st_req;
   logic [4:0]  wa_addr, wb_addr, ld_rd, st_rs;
   logic [31:0] wa_data, wb_data;

   logic [63:0] rd_data_b, rd_data_n;
   logic [31:0] st_data_b, st_data_n;
   logic        st_valid_b, st_valid_n, stall_b, stall_n;
   logic        pend_full_b, pend_full_n, ovf_b, ovf_n;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   register_file_sb #(.BYPASS(1)) u_byp (
      .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_used(rd_used), .rd_data(rd_data_b),
      .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .ld_issue(ld_issue), .ld_rd(ld_rd), .st_req(st_req), .st_rs(st_rs),
      .st_data(st_data_b), .st_valid(st_valid_b), .stall(stall_b),
      .pend_full(pend_full_b), .ovf(ovf_b)
   );

   register_file_sb #(.BYPASS(0)) u_nbp (
      .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_used(rd_used), .rd_data(rd_data_n),
      .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .ld_issue(ld_issue), .ld_rd(ld_rd), .st_req(st_req), .st_rs(st_rs),
      .st_data(st_data_n), .st_valid(st_valid_n), .stall(stall_n),
      .pend_full(pend_full_n), .ovf(ovf_n)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wa_en = 0; wb_en = 0; ld_issue = 0; st_req = 0; rd_used = 0;
   endtask

   initial begin
      reset = 1; rd_addr = '0; wa_addr = '0; wb_addr = '0; ld_rd = '0; st_rs = '0;
      wa_data = '0; wb_data = '0;
      idle();
      #3;
      chk("rst_st_valid", {31'b0, st_valid_b}, 0);
      chk("rst_st_data", st_data_b, 0);
      chk("rst_pend_full", {31'b0, pend_full_b}, 0);
      chk("rst_ovf", {31'b0, ovf_b}, 0);
      chk("rst_stall", {31'b0, stall_b}, 0);
      @(negedge clk); reset = 0;
      tick();

      // x5 <= DEADBEEF, visible next cycle
      wa_en = 1; wa_addr = 5; wa_data = 32'hDEADBEEF;
      tick(); idle();
      rd_addr[4:0] = 5; #1;
      chk("rd_x5", rd_data_b[31:0], 32'hDEADBEEF);
      chk("rd_x5_nb", rd_data_n[31:0], 32'hDEADBEEF);

      // writes to x0 are dropped, including on the bypass path
      wa_en = 1; wa_addr = 0; wa_data = 32'hFFFF; rd_addr[4:0] = 0; #1;
      chk("x0_byp", rd_data_b[31:0], 0);
      tick(); idle(); #1;
      chk("x0_after", rd_data_b[31:0], 0);

      // same-cycle forwarding on port 1
      wa_en = 1; wa_addr = 7; wa_data = 32'h11; rd_addr[9:5] = 7; #1;
      chk("byp_x7", rd_data_b[63:32], 32'h11);
      chk("nobyp_x7", rd_data_n[63:32], 0);
      tick(); idle(); #1;
      chk("nobyp_x7_later", rd_data_n[63:32], 32'h11);

      // A/B collision: A wins, also on the bypass path
      wa_en = 1; wa_addr = 3; wa_data = 32'hA; wb_en = 1; wb_addr = 3; wb_data = 32'hB;
      rd_addr[4:0] = 3; #1;
      chk("coll_byp", rd_data_b[31:0], 32'hA);
      tick(); idle(); #1;
      chk("coll_x3", rd_data_n[31:0], 32'hA);
      wa_en = 1; wa_addr = 4; wa_data = 32'h1; wb_en = 1; wb_addr = 6; wb_data = 32'h2;
      tick(); idle();
      rd_addr[4:0] = 4; rd_addr[9:5] = 6; #1;
      chk("dist_x4", rd_data_n[31:0], 32'h1);
      chk("dist_x6", rd_data_n[63:32], 32'h2);

      // load to x9 makes it busy; return clears stall same cycle only with bypass
      ld_issue = 1; ld_rd = 9;
      tick(); idle();
      rd_used = 2'b01; rd_addr[4:0] = 9; #1;
      chk("stall_x9", {31'b0, stall_b}, 1);
      chk("stall_x9_port1_unused", {31'b0, stall_n}, 1);
      wb_en = 1; wb_addr = 9; wb_data = 32'h55; #1;
      chk("stall_wb_byp", {31'b0, stall_b}, 0);
      chk("stall_wb_nobyp", {31'b0, stall_n}, 1);
      chk("rd_wb_byp", rd_data_b[31:0], 32'h55);
      chk("rd_wb_nobyp", rd_data_n[31:0], 0);
      tick(); wb_en = 0; #1;
      chk("stall_after_wb", {31'b0, stall_n}, 0);
      chk("x9_val", rd_data_n[31:0], 32'h55);

      // set and clear of x9 in the same cycle: stays busy
      ld_issue = 1; ld_rd = 9; wb_en = 1; wb_addr = 9; wb_data = 32'h66;
      tick(); ld_issue = 0; wb_en = 0; #1;
      chk("set_wins", {31'b0, stall_n}, 1);
      wb_en = 1; wb_addr = 9; wb_data = 32'h66;
      tick(); idle(); #1;
      chk("x9_cleared", {31'b0, stall_b}, 0);

      // fill the outstanding-load counter
      for (int i = 0; i < 4; i++) begin
         ld_issue = 1; ld_rd = 5'(10 + i);
         tick(); ld_issue = 0; #1;
         chk("pend_full_fill", {31'b0, pend_full_b}, (i == 3) ? 32'd1 : 32'd0);
      end
      ld_issue = 1; ld_rd = 14;
      tick(); ld_issue = 0; #1;
      chk("ovf_set", {31'b0, ovf_b}, 1);
      rd_used = 2'b01; rd_addr[4:0] = 14; #1;
      chk("ovf_no_busy", {31'b0, stall_b}, 0);
      rd_addr[4:0] = 13; #1;
      chk("x13_busy", {31'b0, stall_b}, 1);
      rd_used = 0;
      wb_en = 1; wb_addr = 10; wb_data = 32'h77;
      tick(); idle(); #1;
      chk("pend_drop", {31'b0, pend_full_b}, 0);
      chk("ovf_sticky", {31'b0, ovf_n}, 1);

      // store of x5 while x5 is being rewritten: bypass captures new data
      wa_en = 1; wa_addr = 5; wa_data = 32'h1234; st_req = 1; st_rs = 5;
      tick(); idle(); #1;
      chk("st_valid", {31'b0, st_valid_b}, 1);
      chk("st_data_byp", st_data_b, 32'h1234);
      chk("st_data_nobyp", st_data_n, 32'hDEADBEEF);
      tick(); #1;
      chk("st_valid_drop", {31'b0, st_valid_b}, 0);
      chk("st_data_hold", st_data_b, 32'h1234);

      // refill counter with a store in flight, then async reset mid-cycle
      ld_issue = 1; ld_rd = 20; st_req = 1; st_rs = 3;
      tick(); idle(); #1;
      chk("refull", {31'b0, pend_full_b}, 1);
      chk("st_valid2", {31'b0, st_valid_b}, 1);
      rd_used = 2'b01; rd_addr[4:0] = 13; rd_addr[9:5] = 5;
      reset = 1; #1;
      chk("arst_pend_full", {31'b0, pend_full_b}, 0);
      chk("arst_ovf", {31'b0, ovf_b}, 0);
      chk("arst_st_valid", {31'b0, st_valid_b}, 0);
      chk("arst_st_data", st_data_b, 0);
      chk("arst_stall", {31'b0, stall_b}, 0);
      chk("arst_x5", rd_data_n[63:32], 0);
      @(negedge clk); reset = 0; rd_used = 0;

      // load return after reset only writes data; counter must not underflow
      wb_en = 1; wb_addr = 20; wb_data = 32'h99;
      tick(); idle();
      for (int i = 0; i < 4; i++) begin
         ld_issue = 1; ld_rd = 5'(1 + i);
         tick();
      end
      idle(); #1;
      chk("no_underflow", {31'b0, pend_full_b}, 1);
      rd_addr[4:0] = 20; #1;
      chk("wb_after_rst", rd_data_b[31:0], 32'h99);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
